video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised raster timing generator for the video pipeline, and the successor to the fixed-mode timing block. All timing values and counter widths are module parameters, so one RTL serves every supported video mode. Adds an exported vertical counter, a frame counter, a run/hold control and an optional raster-line compare strobe. It sits on the pixel clock and feeds sync/DE to the DVI/VGA output stage and line/frame strobes to the pixel fetch logic.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels (≥1)
- H_SYNC, 96, hsync width in pixels (≥1)
- H_BACK, 48, horizontal back porch in pixels (≥1)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch in lines (≥1)
- V_SYNC, 2, vsync width in lines (≥1)
- V_BACK, 33, vertical back porch in lines (≥1)
- H_SYNC_POL, 0, active level of hsync_o
- V_SYNC_POL, 0, active level of vsync_o
- HRES_W, 10, h counter width; must hold H_TOTAL-1
- VRES_W, 10, v counter width; must hold V_TOTAL-1
- FRAME_W, 8, frame counter width

Ports:
- clk  in  1  pixel clock
- reset_i  in  1  reset; asynchronous, active-high
- run_i  in  1  1 = advance timing; 0 = hold all state
- line_cmp_i  in  VRES_W  line number for the compare strobe
- h_count_o  out  HRES_W  horizontal counter
- v_count_o  out  VRES_W  vertical counter
- frame_count_o  out  FRAME_W  completed-frame counter
- v_visible_o  out  1  current line is visible
- dv_de_o  out  1  display enable: visible pixel
- hsync_o  out  1  horizontal sync
- vsync_o  out  1  vertical sync
- end_of_line_o  out  1  strobe, first pixel of a new line
- end_of_frame_o  out  1  strobe, first pixel of a new frame
- line_irq_o  out  1  line compare strobe; present only with the macro

## Operation
- Totals: H_TOTAL = H_FRONT+H_SYNC+H_BACK+H_VISIBLE and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK.
- Horizontal FSM runs PRE_SYNC, SYNC, POST_SYNC, VISIBLE, then wraps. Non-visible pixels come first on each line.
  - Each state advances when h_count equals its cumulative end: H_FRONT-1, then H_FRONT+H_SYNC-1, then H_FRONT+H_SYNC+H_BACK-1, then H_TOTAL-1.
- Vertical FSM runs VISIBLE, PRE_SYNC, SYNC, POST_SYNC, then wraps. Visible lines come first.
  - States change only on a line wrap, at cumulative ends V_VISIBLE-1, +V_FRONT, +V_SYNC, and V_TOTAL-1.
- h_count increments each running cycle and wraps from H_TOTAL-1 to 0. On that wrap, v_count increments, wrapping from V_TOTAL-1 to 0.
- frame_count increments modulo 2^FRAME_W on each v_count wrap.
- hsync_o is active when H state = SYNC. vsync_o is active when V state = SYNC. Inactive level is the inverse of the polarity parameter.
- dv_de_o = H VISIBLE and V VISIBLE. v_visible_o = V VISIBLE.
- end_of_line_o is high for one cycle when h_count_o has just wrapped to 0. end_of_frame_o is additionally qualified by v_count_o having wrapped to 0.
- run_i=0 freezes every register. Strobes in flight are held as well, so a strobe lasts exactly one running cycle.
- Reset is asynchronous and takes effect immediately, mid-line or mid-frame. Reset values:
  - counters 0, H state PRE_SYNC, V state VISIBLE
  - hsync/vsync inactive
  - dv_de_o, end_of_line_o, end_of_frame_o, line_irq_o all 0
  - v_visible_o 1
- The first line after reset emits no end_of_line_o. The first frame emits no end_of_frame_o.

## Timing
- Every output is registered and is computed from next-state logic. All outputs describe the same pixel as h_count_o/v_count_o, with zero skew between them.
- run_i is sampled each clk. Hold takes effect in the same edge.
- line_cmp_i is sampled on the line-wrap edge only. Changing it mid-line is safe.

## Configuration
- VIDEO_TIMING_LINE_IRQ_EN defined:
  - line_irq_o pulses for one cycle, coincident with end_of_line_o, when the new v_count equals line_cmp_i.
  - line_cmp_i ≥ V_TOTAL never fires.
  - line_cmp_i = 0 fires together with end_of_frame_o.
- Undefined: line_irq_o is tied 0, line_cmp_i is unused, and no compare logic is synthesised.

## Test plan
- Defaults, reset released: hsync_o low for h_count 16..111, dv_de_o high for h 160..799 on lines 0..479, vsync_o low on lines 490..491.
- Defaults, free run for 2 frames: end_of_frame_o exactly every 420000 cycles; end_of_line_o every 800 cycles; frame_count_o increments by 1 per frame. No strobe occurs in the first line or frame.
- run_i low for 37 cycles at h=500, v=200: all outputs hold. Resuming continues at h=501 and the frame period stretches to 420037.
- reset_i asserted asynchronously mid-hsync (between clk edges): outputs take reset values before the next edge. After release, the sequence matches the first scenario.
- Macro on, line_cmp_i=100: line_irq_o is a single pulse at v=100, h=0. With line_cmp_i=600: no pulse. Macro off: line_irq_o constant 0.
- Small mode (H 8/1/1/1, V 4/1/1/1, HRES_W=4, VRES_W=3): H_TOTAL=11, V_TOTAL=7. Check wrap points and polarity swap with H_SYNC_POL=V_SYNC_POL=1.

Source files
------------

// File: rtl/video_timing_if.sv
// Raster timing bundle from video_timing_gen to the output stage and pixel fetch logic.
interface video_timing_if #(
    parameter int unsigned HRES_W  = 10,
    parameter int unsigned VRES_W  = 10,
    parameter int unsigned FRAME_W = 8
);
    logic [HRES_W-1:0]  h_count_o;
    logic [VRES_W-1:0]  v_count_o;
    logic [FRAME_W-1:0] frame_count_o;
    logic               v_visible_o;
    logic               dv_de_o;
    logic               hsync_o;
    logic               vsync_o;
    logic               end_of_line_o;
    logic               end_of_frame_o;
    logic               line_irq_o;

    modport master (
        output h_count_o, v_count_o, frame_count_o, v_visible_o, dv_de_o,
               hsync_o, vsync_o, end_of_line_o, end_of_frame_o, line_irq_o
    );
    modport slave (
        input  h_count_o, v_count_o, frame_count_o, v_visible_o, dv_de_o,
               hsync_o, vsync_o, end_of_line_o, end_of_frame_o, line_irq_o
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator; blanking first on each line, visible lines first per frame.
// Optional raster-line compare strobe enabled by defining VIDEO_TIMING_LINE_IRQ_EN.
module video_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    parameter int unsigned HRES_W     = 10,
    parameter int unsigned VRES_W     = 10,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic [VRES_W-1:0] line_cmp_i,
    video_timing_if.master    vt_o
);
    localparam int unsigned H_TOTAL = H_FRONT + H_SYNC + H_BACK + H_VISIBLE;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [HRES_W-1:0] H_END_PRE  = HRES_W'(H_FRONT - 1);
    localparam logic [HRES_W-1:0] H_END_SYNC = HRES_W'(H_FRONT + H_SYNC - 1);
    localparam logic [HRES_W-1:0] H_END_POST = HRES_W'(H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [HRES_W-1:0] H_END      = HRES_W'(H_TOTAL - 1);
    localparam logic [VRES_W-1:0] V_END_VIS  = VRES_W'(V_VISIBLE - 1);
    localparam logic [VRES_W-1:0] V_END_PRE  = VRES_W'(V_VISIBLE + V_FRONT - 1);
    localparam logic [VRES_W-1:0] V_END_SYNC = VRES_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [VRES_W-1:0] V_END      = VRES_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {HPreSync, HSync, HPostSync, HVisible} h_state_e;
    typedef enum logic [1:0] {VVisible, VPreSync, VSync, VPostSync} v_state_e;

    h_state_e           h_state_q, h_state_d;
    v_state_e           v_state_q, v_state_d;
    logic [HRES_W-1:0]  h_count_q, h_count_d;
    logic [VRES_W-1:0]  v_count_q, v_count_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, vvis_q, vvis_d;
    logic eol_q, eol_d, eof_q, eof_d, irq_q, irq_d;
    logic h_wrap, v_wrap, line_wrap, frame_wrap;

    always_comb begin
        h_wrap     = (h_count_q == H_END);
        v_wrap     = (v_count_q == V_END);
        line_wrap  = run_i & h_wrap;
        frame_wrap = line_wrap & v_wrap;

        h_count_d = h_count_q;
        v_count_d = v_count_q;
        frame_d   = frame_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        eol_d     = eol_q;
        eof_d     = eof_q;

        if (run_i) begin
            h_count_d = h_wrap ? '0 : h_count_q + 1'b1;
            eol_d     = line_wrap;
            eof_d     = frame_wrap;
            unique case (h_state_q)
                HPreSync:  if (h_count_q == H_END_PRE)  h_state_d = HSync;
                HSync:     if (h_count_q == H_END_SYNC) h_state_d = HPostSync;
                HPostSync: if (h_count_q == H_END_POST) h_state_d = HVisible;
                HVisible:  if (h_wrap)                  h_state_d = HPreSync;
                default:                                h_state_d = HPreSync;
            endcase
        end
        if (line_wrap) begin
            v_count_d = v_wrap ? '0 : v_count_q + 1'b1;
            unique case (v_state_q)
                VVisible:  if (v_count_q == V_END_VIS)  v_state_d = VPreSync;
                VPreSync:  if (v_count_q == V_END_PRE)  v_state_d = VSync;
                VSync:     if (v_count_q == V_END_SYNC) v_state_d = VPostSync;
                VPostSync: if (v_wrap)                  v_state_d = VVisible;
                default:                                v_state_d = VVisible;
            endcase
        end
        if (frame_wrap) frame_d = frame_q + 1'b1;

        // Outputs are registered from next state so they line up with the counters.
        hsync_d = (h_state_d == HSync) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d = (v_state_d == VSync) ? V_SYNC_POL : ~V_SYNC_POL;
        vvis_d  = (v_state_d == VVisible);
        de_d    = (h_state_d == HVisible) && vvis_d;
    end

`ifdef VIDEO_TIMING_LINE_IRQ_EN
    always_comb begin
        irq_d = irq_q;
        if (run_i) irq_d = line_wrap && (v_count_d == line_cmp_i);
    end
`else
    logic unused_line_cmp;
    assign unused_line_cmp = ^line_cmp_i;
    assign irq_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            h_state_q <= HPreSync;
            v_state_q <= VVisible;
            h_count_q <= '0;
            v_count_q <= '0;
            frame_q   <= '0;
            hsync_q   <= ~H_SYNC_POL;
            vsync_q   <= ~V_SYNC_POL;
            de_q      <= 1'b0;
            vvis_q    <= 1'b1;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
            frame_q   <= frame_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            vvis_q    <= vvis_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
            irq_q     <= irq_d;
        end
    end

    assign vt_o.h_count_o      = h_count_q;
    assign vt_o.v_count_o      = v_count_q;
    assign vt_o.frame_count_o  = frame_q;
    assign vt_o.v_visible_o    = vvis_q;
    assign vt_o.dv_de_o        = de_q;
    assign vt_o.hsync_o        = hsync_q;
    assign vt_o.vsync_o        = vsync_q;
    assign vt_o.end_of_line_o  = eol_q;
    assign vt_o.end_of_frame_o = eof_q;
    assign vt_o.line_irq_o     = irq_q;
endmodule
